// File: rtl/issue_slot_if.sv
// uop_interface: micro-op bundle passed between dispatch, issue slots and
// the issue port. input_port is the consumer view (all members are inputs);
// output_port is the issue view. bits_debug_pc is carried into the slot but
// has no output_port member, so it is held and never driven back out.
interface uop_interface #(
  parameter int PREG_SZ    = 7,
  parameter int BR_MASK_SZ = 12
);
  logic                  valid;
  logic [1:0]            iw_state;
  logic [6:0]            bits_uopc;
  logic [5:0]            bits_rob_idx;
  logic [PREG_SZ-1:0]    bits_pdst;
  logic [PREG_SZ-1:0]    bits_prs1;
  logic [PREG_SZ-1:0]    bits_prs2;
  logic                  bits_prs1_busy;
  logic                  bits_prs2_busy;
  logic [4:0]            bits_ppred;
  logic                  bits_ppred_busy;
  logic [BR_MASK_SZ-1:0] bits_br_mask;
  logic [31:0]           bits_debug_pc;

  modport input_port (
    input valid, iw_state, bits_uopc, bits_rob_idx, bits_pdst,
          bits_prs1, bits_prs2, bits_prs1_busy, bits_prs2_busy,
          bits_ppred, bits_ppred_busy, bits_br_mask, bits_debug_pc
  );

  modport output_port (
    output valid, iw_state, bits_uopc, bits_rob_idx, bits_pdst,
           bits_prs1, bits_prs2, bits_prs1_busy, bits_prs2_busy,
           bits_ppred, bits_ppred_busy, bits_br_mask
  );
endinterface

// File: rtl/issue_slot.sv
// issue_slot: one entry of an out-of-order issue queue.
// Holds a dispatched uop, clears operand busy bits on wakeup broadcasts,
// tracks speculation through its branch mask, requests issue when its
// operands are ready, and frees itself (or downgrades a split store to its
// data half) on grant.
// Optional feature: define ISSUE_SLOT_PPRED_EN to add predicate wakeup
// ports and make issue also wait on the predicate busy bit.
module issue_slot #(
  parameter int NUM_WAKEUP = 2,
  parameter int PREG_SZ    = 7,
  parameter int BR_MASK_SZ = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uop_interface.input_port              in_uop,
  output logic                          in_ready,
  input  logic [NUM_WAKEUP-1:0]         wakeup_valid,
  input  logic [NUM_WAKEUP*PREG_SZ-1:0] wakeup_pdst,
  input  logic                          br_valid,
  input  logic [BR_MASK_SZ-1:0]         br_mask,
  input  logic                          br_mispredict,
  input  logic                          flush,
  output logic                          request,
  input  logic                          grant,
  uop_interface.output_port             out_uop,
  output logic                          slot_valid
`ifdef ISSUE_SLOT_PPRED_EN
  ,
  input  logic                          pred_wakeup_valid,
  input  logic [4:0]                    pred_wakeup_idx
`endif
);

  typedef enum logic [1:0] {
    IW_INVALID = 2'd0,
    IW_VALID_1 = 2'd1,
    IW_VALID_2 = 2'd2,
    IW_RSVD    = 2'd3
  } iw_state_e;

  // True when any wakeup port broadcasts the given tag this cycle.
  function automatic logic tag_woken(
    input logic [PREG_SZ-1:0]            tag,
    input logic [NUM_WAKEUP-1:0]         valids,
    input logic [NUM_WAKEUP*PREG_SZ-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_WAKEUP; i++) begin
      if (valids[i] && (tags[i*PREG_SZ +: PREG_SZ] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // Mask with the resolved branch bit removed when a resolve is present.
  function automatic logic [BR_MASK_SZ-1:0] mask_after_resolve(
    input logic [BR_MASK_SZ-1:0] mask,
    input logic                  resolve,
    input logic [BR_MASK_SZ-1:0] resolved
  );
    return resolve ? (mask & ~resolved) : mask;
  endfunction

  iw_state_e             state_r;
  logic [6:0]            uopc_r;
  logic [5:0]            rob_idx_r;
  logic [PREG_SZ-1:0]    pdst_r;
  logic [PREG_SZ-1:0]    prs1_r;
  logic [PREG_SZ-1:0]    prs2_r;
  logic                  prs1_busy_r;
  logic                  prs2_busy_r;
  logic [4:0]            ppred_r;
  logic                  ppred_busy_r;
  logic [BR_MASK_SZ-1:0] br_mask_r;
  // Carried along with the uop but never presented on the output view.
  logic [31:0]           debug_pc_unused_r;

  logic prs1_wake_s;
  logic prs2_wake_s;
  logic in_prs1_wake_s;
  logic in_prs2_wake_s;
  logic ppred_wake_s;
  logic in_ppred_wake_s;
  logic ppred_ok_s;
  logic kill_s;
  logic in_kill_s;
  logic in_state_ok_s;
  logic dispatch_fire_s;
  logic grant_fire_s;

  // Wakeup tag matches against the stored and the incoming operand tags.
  always_comb begin
    prs1_wake_s    = tag_woken(prs1_r, wakeup_valid, wakeup_pdst);
    prs2_wake_s    = tag_woken(prs2_r, wakeup_valid, wakeup_pdst);
    in_prs1_wake_s = tag_woken(in_uop.bits_prs1, wakeup_valid, wakeup_pdst);
    in_prs2_wake_s = tag_woken(in_uop.bits_prs2, wakeup_valid, wakeup_pdst);
  end

`ifdef ISSUE_SLOT_PPRED_EN
  // Predicate wakeup matches; issue also waits for the predicate.
  always_comb begin
    ppred_wake_s    = pred_wakeup_valid && (pred_wakeup_idx == ppred_r);
    in_ppred_wake_s = pred_wakeup_valid && (pred_wakeup_idx == in_uop.bits_ppred);
    ppred_ok_s      = !ppred_busy_r;
  end
`else
  // Predicates are not tracked: never busy, never block issue.
  logic unused_in_ppred_busy_s;
  always_comb begin
    ppred_wake_s           = 1'b0;
    in_ppred_wake_s        = 1'b0;
    ppred_ok_s             = 1'b1;
    unused_in_ppred_busy_s = in_uop.bits_ppred_busy;
  end
`endif

  // Slot status and ready-to-accept.
  always_comb begin
    slot_valid = (state_r != IW_INVALID);
    in_ready   = (state_r == IW_INVALID);
  end

  // Issue request from registered state and busy bits.
  always_comb begin
    request = 1'b0;
    case (state_r)
      IW_VALID_1: request = !prs1_busy_r && !prs2_busy_r && ppred_ok_s;
      IW_VALID_2: request = !prs1_busy_r && ppred_ok_s;
      default:    request = 1'b0;
    endcase
  end

  // Kill, grant and dispatch qualification. A kill needs a live slot so a
  // stale mask in an empty slot cannot block a new dispatch.
  always_comb begin
    kill_s          = slot_valid && br_valid && br_mispredict &&
                      (|(br_mask & br_mask_r));
    in_kill_s       = br_valid && br_mispredict &&
                      (|(br_mask & in_uop.bits_br_mask));
    in_state_ok_s   = (in_uop.iw_state == 2'd1) || (in_uop.iw_state == 2'd2);
    grant_fire_s    = grant && request;
    if (in_uop.valid && in_ready && !flush && !in_kill_s && in_state_ok_s) begin
      dispatch_fire_s = 1'b1;
    end else begin
      dispatch_fire_s = 1'b0;
    end
  end

  // Slot state machine: flush > mispredict kill > grant > dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IW_INVALID;
    end else if (flush) begin
      state_r <= IW_INVALID;
    end else if (kill_s) begin
      state_r <= IW_INVALID;
    end else if (grant_fire_s) begin
      case (state_r)
        IW_VALID_2: state_r <= prs2_busy_r ? IW_VALID_1 : IW_INVALID;
        default:    state_r <= IW_INVALID;
      endcase
    end else if (dispatch_fire_s) begin
      state_r <= iw_state_e'(in_uop.iw_state);
    end else begin
      state_r <= state_r;
    end
  end

  // Payload capture on dispatch; otherwise apply wakeups and branch resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uopc_r            <= 7'd0;
      rob_idx_r         <= 6'd0;
      pdst_r            <= '0;
      prs1_r            <= '0;
      prs2_r            <= '0;
      prs1_busy_r       <= 1'b0;
      prs2_busy_r       <= 1'b0;
      ppred_r           <= 5'd0;
      ppred_busy_r      <= 1'b0;
      br_mask_r         <= '0;
      debug_pc_unused_r <= 32'd0;
    end else if (dispatch_fire_s) begin
      uopc_r            <= in_uop.bits_uopc;
      rob_idx_r         <= in_uop.bits_rob_idx;
      pdst_r            <= in_uop.bits_pdst;
      prs1_r            <= in_uop.bits_prs1;
      prs2_r            <= in_uop.bits_prs2;
      prs1_busy_r       <= in_uop.bits_prs1_busy && !in_prs1_wake_s;
      prs2_busy_r       <= in_uop.bits_prs2_busy && !in_prs2_wake_s;
      ppred_r           <= in_uop.bits_ppred;
`ifdef ISSUE_SLOT_PPRED_EN
      ppred_busy_r      <= in_uop.bits_ppred_busy && !in_ppred_wake_s;
`else
      ppred_busy_r      <= 1'b0;
`endif
      br_mask_r         <= mask_after_resolve(in_uop.bits_br_mask, br_valid, br_mask);
      debug_pc_unused_r <= in_uop.bits_debug_pc;
    end else begin
      if (prs1_wake_s) begin
        prs1_busy_r <= 1'b0;
      end
      if (prs2_wake_s) begin
        prs2_busy_r <= 1'b0;
      end
      if (ppred_wake_s) begin
        ppred_busy_r <= 1'b0;
      end
      br_mask_r <= mask_after_resolve(br_mask_r, br_valid, br_mask);
    end
  end

  // Output view of the held uop.
  always_comb begin
    out_uop.valid           = slot_valid;
    out_uop.iw_state        = state_r;
    out_uop.bits_uopc       = uopc_r;
    out_uop.bits_rob_idx    = rob_idx_r;
    out_uop.bits_pdst       = pdst_r;
    out_uop.bits_prs1       = prs1_r;
    out_uop.bits_prs2       = prs2_r;
    out_uop.bits_prs1_busy  = prs1_busy_r;
    out_uop.bits_prs2_busy  = prs2_busy_r;
    out_uop.bits_ppred      = ppred_r;
    out_uop.bits_ppred_busy = ppred_busy_r;
    out_uop.bits_br_mask    = br_mask_r;
  end

endmodule

// File: tb/tb_issue_slot.sv
// Directed self-checking bench for issue_slot.
module tb_issue_slot;

  logic        clk;
  logic        rst_n;
  logic        in_ready;
  logic [1:0]  wakeup_valid;
  logic [13:0] wakeup_pdst;
  logic        br_valid;
  logic [11:0] br_mask;
  logic        br_mispredict;
  logic        flush;
  logic        request;
  logic        grant;
  logic        slot_valid;
`ifdef ISSUE_SLOT_PPRED_EN
  logic        pred_wakeup_valid;
  logic [4:0]  pred_wakeup_idx;
`endif

  int n_pass;
  int n_total;

  uop_interface in_if ();
  uop_interface out_if ();

  assign out_if.bits_debug_pc = 32'd0;

  issue_slot dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_uop        (in_if),
    .in_ready      (in_ready),
    .wakeup_valid  (wakeup_valid),
    .wakeup_pdst   (wakeup_pdst),
    .br_valid      (br_valid),
    .br_mask       (br_mask),
    .br_mispredict (br_mispredict),
    .flush         (flush),
    .request       (request),
    .grant         (grant),
    .out_uop       (out_if),
    .slot_valid    (slot_valid)
`ifdef ISSUE_SLOT_PPRED_EN
    ,
    .pred_wakeup_valid (pred_wakeup_valid),
    .pred_wakeup_idx   (pred_wakeup_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    in_if.valid           = 1'b0;
    in_if.iw_state        = 2'd0;
    in_if.bits_uopc       = 7'd0;
    in_if.bits_rob_idx    = 6'd0;
    in_if.bits_pdst       = 7'd0;
    in_if.bits_prs1       = 7'd0;
    in_if.bits_prs2       = 7'd0;
    in_if.bits_prs1_busy  = 1'b0;
    in_if.bits_prs2_busy  = 1'b0;
    in_if.bits_ppred      = 5'd0;
    in_if.bits_ppred_busy = 1'b0;
    in_if.bits_br_mask    = 12'd0;
    in_if.bits_debug_pc   = 32'd0;
    wakeup_valid          = 2'b00;
    wakeup_pdst           = 14'd0;
    br_valid              = 1'b0;
    br_mask               = 12'd0;
    br_mispredict         = 1'b0;
    flush                 = 1'b0;
    grant                 = 1'b0;
`ifdef ISSUE_SLOT_PPRED_EN
    pred_wakeup_valid     = 1'b0;
    pred_wakeup_idx       = 5'd0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dispatch(input logic [1:0] st, input logic [6:0] p1, input logic b1,
                                input logic [6:0] p2, input logic b2, input logic [11:0] m);
    in_if.valid          = 1'b1;
    in_if.iw_state       = st;
    in_if.bits_uopc      = 7'd17;
    in_if.bits_rob_idx   = 6'd9;
    in_if.bits_pdst      = 7'd40;
    in_if.bits_prs1      = p1;
    in_if.bits_prs1_busy = b1;
    in_if.bits_prs2      = p2;
    in_if.bits_prs2_busy = b2;
    in_if.bits_br_mask   = m;
    in_if.bits_debug_pc  = 32'h1000;
  endtask

  task automatic clear_slot();
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    n_total++; if (out_if.valid !== 1'b0) $display("FAIL por_valid: got %0b want 0", out_if.valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL por_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_if.bits_br_mask !== 12'h000) $display("FAIL por_mask: got %h want 000", out_if.bits_br_mask); else n_pass++;
    #9 rst_n = 1'b1;
    tick();
    drive_dispatch(2'd1, 7'd1, 1'b0, 7'd2, 1'b0, 12'h001);
    tick();
    idle();
    n_total++; if (request !== 1'b1) $display("FAIL pre_reset_request: got %0b want 1", request); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_if.iw_state !== 2'd0) $display("FAIL async_state: got %0d want 0", out_if.iw_state); else n_pass++;
    n_total++; if (request !== 1'b0) $display("FAIL async_request: got %0b want 0", request); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL async_in_ready: got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_if.valid !== 1'b0) $display("FAIL async_valid: got %0b want 0", out_if.valid); else n_pass++;
    n_total++; if (out_if.bits_prs1 !== 7'd0) $display("FAIL async_prs1: got %0d want 0", out_if.bits_prs1); else n_pass++;
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wakeup_issue();
    drive_dispatch(2'd1, 7'd5, 1'b1, 7'd9, 1'b0, 12'h000);
    tick();
    idle();
    n_total++; if (request !== 1'b0) $display("FAIL wk_request_busy: got %0b want 0", request); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL wk_in_ready: got %0b want 0", in_ready); else n_pass++;
    // wrong tag on port 0 must not wake
    wakeup_valid = 2'b01;
    wakeup_pdst  = {7'd0, 7'd4};
    tick();
    idle();
    n_total++; if (request !== 1'b0) $display("FAIL wk_wrong_tag: got %0b want 0", request); else n_pass++;
    wakeup_valid = 2'b10;
    wakeup_pdst  = {7'd5, 7'd3};
    n_total++; if (request !== 1'b0) $display("FAIL wk_same_cycle: got %0b want 0", request); else n_pass++;
    tick();
    idle();
    n_total++; if (request !== 1'b1) $display("FAIL wk_request_ready: got %0b want 1", request); else n_pass++;
    n_total++; if (out_if.bits_prs1_busy !== 1'b0) $display("FAIL wk_prs1_busy: got %0b want 0", out_if.bits_prs1_busy); else n_pass++;
    grant = 1'b1;
    #1;
    n_total++; if (out_if.iw_state !== 2'd1) $display("FAIL wk_grant_cycle_state: got %0d want 1", out_if.iw_state); else n_pass++;
    tick();
    idle();
    n_total++; if (out_if.iw_state !== 2'd0) $display("FAIL wk_after_grant_state: got %0d want 0", out_if.iw_state); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL wk_after_grant_ready: got %0b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_store_split();
    drive_dispatch(2'd2, 7'd3, 1'b0, 7'd12, 1'b1, 12'h000);
    tick();
    idle();
    n_total++; if (request !== 1'b1) $display("FAIL st_addr_request: got %0b want 1", request); else n_pass++;
    n_total++; if (out_if.iw_state !== 2'd2) $display("FAIL st_state2: got %0d want 2", out_if.iw_state); else n_pass++;
    grant = 1'b1;
    tick();
    idle();
    n_total++; if (out_if.iw_state !== 2'd1) $display("FAIL st_downgrade: got %0d want 1", out_if.iw_state); else n_pass++;
    n_total++; if (request !== 1'b0) $display("FAIL st_data_wait: got %0b want 0", request); else n_pass++;
    wakeup_valid = 2'b01;
    wakeup_pdst  = {7'd0, 7'd12};
    tick();
    idle();
    n_total++; if (request !== 1'b1) $display("FAIL st_data_request: got %0b want 1", request); else n_pass++;
    grant = 1'b1;
    tick();
    idle();
    n_total++; if (out_if.iw_state !== 2'd0) $display("FAIL st_done: got %0d want 0", out_if.iw_state); else n_pass++;
  endtask

  task automatic test_branch();
    drive_dispatch(2'd1, 7'd20, 1'b1, 7'd21, 1'b1, 12'h004);
    tick();
    idle();
    n_total++; if (out_if.bits_br_mask !== 12'h004) $display("FAIL br_capture: got %h want 004", out_if.bits_br_mask); else n_pass++;
    // mispredict of a branch the uop does not depend on
    br_valid = 1'b1; br_mask = 12'h001; br_mispredict = 1'b1;
    tick();
    idle();
    n_total++; if (out_if.iw_state !== 2'd1) $display("FAIL br_other_kill: got %0d want 1", out_if.iw_state); else n_pass++;
    br_valid = 1'b1; br_mask = 12'h004;
    tick();
    idle();
    n_total++; if (out_if.bits_br_mask !== 12'h000) $display("FAIL br_resolve_mask: got %h want 000", out_if.bits_br_mask); else n_pass++;
    n_total++; if (out_if.iw_state !== 2'd1) $display("FAIL br_resolve_state: got %0d want 1", out_if.iw_state); else n_pass++;
    clear_slot();
    drive_dispatch(2'd1, 7'd20, 1'b1, 7'd21, 1'b1, 12'h004);
    tick();
    idle();
    br_valid = 1'b1; br_mask = 12'h004; br_mispredict = 1'b1;
    tick();
    idle();
    n_total++; if (out_if.iw_state !== 2'd0) $display("FAIL br_kill: got %0d want 0", out_if.iw_state); else n_pass++;
  endtask

  task automatic test_kill_vs_grant();
    drive_dispatch(2'd2, 7'd1, 1'b0, 7'd30, 1'b1, 12'h008);
    tick();
    idle();
    grant = 1'b1; br_valid = 1'b1; br_mask = 12'h008; br_mispredict = 1'b1;
    tick();
    idle();
    n_total++; if (out_if.iw_state !== 2'd0) $display("FAIL kill_over_grant: got %0d want 0", out_if.iw_state); else n_pass++;
    drive_dispatch(2'd2, 7'd1, 1'b0, 7'd30, 1'b1, 12'h008);
    tick();
    idle();
    grant = 1'b1; flush = 1'b1;
    tick();
    idle();
    n_total++; if (out_if.iw_state !== 2'd0) $display("FAIL flush_over_grant: got %0d want 0", out_if.iw_state); else n_pass++;
  endtask

  task automatic test_dispatch_wakeup();
    drive_dispatch(2'd1, 7'd7, 1'b1, 7'd0, 1'b0, 12'h030);
    wakeup_valid = 2'b01; wakeup_pdst = {7'd0, 7'd7};
    br_valid = 1'b1; br_mask = 12'h010;
    tick();
    idle();
    n_total++; if (out_if.bits_prs1_busy !== 1'b0) $display("FAIL dw_prs1_busy: got %0b want 0", out_if.bits_prs1_busy); else n_pass++;
    n_total++; if (request !== 1'b1) $display("FAIL dw_request: got %0b want 1", request); else n_pass++;
    n_total++; if (out_if.bits_br_mask !== 12'h020) $display("FAIL dw_mask: got %h want 020", out_if.bits_br_mask); else n_pass++;
    clear_slot();
  endtask

  task automatic test_ignored_dispatch();
    drive_dispatch(2'd3, 7'd2, 1'b0, 7'd3, 1'b0, 12'h000);
    tick();
    idle();
    n_total++; if (slot_valid !== 1'b0) $display("FAIL ign_state3: got %0b want 0", slot_valid); else n_pass++;
    drive_dispatch(2'd1, 7'd20, 1'b1, 7'd0, 1'b0, 12'h000);
    tick();
    drive_dispatch(2'd1, 7'd30, 1'b0, 7'd0, 1'b0, 12'h000);
    tick();
    idle();
    n_total++; if (out_if.bits_prs1 !== 7'd20) $display("FAIL ign_occupied: got %0d want 20", out_if.bits_prs1); else n_pass++;
    clear_slot();
    drive_dispatch(2'd1, 7'd2, 1'b0, 7'd3, 1'b0, 12'h000);
    in_if.bits_ppred = 5'd6; in_if.bits_ppred_busy = 1'b1;
    tick();
    idle();
`ifdef ISSUE_SLOT_PPRED_EN
    n_total++; if (request !== 1'b0) $display("FAIL pp_request: got %0b want 0", request); else n_pass++;
    pred_wakeup_valid = 1'b1; pred_wakeup_idx = 5'd6;
    tick();
    idle();
    n_total++; if (request !== 1'b1) $display("FAIL pp_woken: got %0b want 1", request); else n_pass++;
`else
    n_total++; if (out_if.bits_ppred_busy !== 1'b0) $display("FAIL pp_busy: got %0b want 0", out_if.bits_ppred_busy); else n_pass++;
    n_total++; if (request !== 1'b1) $display("FAIL pp_request: got %0b want 1", request); else n_pass++;
`endif
    clear_slot();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_wakeup_issue();
    test_store_split();
    test_branch();
    test_kill_vs_grant();
    test_dispatch_wakeup();
    test_ignored_dispatch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
